reservation_station: RTL and testbench
======================================

// Module: reservation_station
// PURPOSE
//  Holds ALU-class instructions issued by the issue stage until both source operands are available.
//  Snoops the ALU and LSB result buses (CDB) to resolve pending ROB tags.
//  Dispatches at most one ready entry per cycle to the ALU.
//  Downstream of issue (consumes rs_push/issue_*), upstream of the ALU.
// PARAMETERS
//  RS_W    4   log2 of entry count; RS_SIZE = 2**RS_W = 16 entries
//  ROB_W   4   ROB index width (tag width)
//  OP_W    6   decoded opcode width
//  DATA_W  32  operand/immediate/pc width
// PORTS
//  clk_in        in   1       clock
//  rst_in        in   1       synchronous active-high reset
//  rdy_in        in   1       global ready; low = freeze
//  flush         in   1       mispredict flush; discard all entries
//  rs_avail      out  1       at least one free entry (combinational, from registered state)
//  rs_avail_pos  out  RS_W    lowest-index free entry (0 when none)
//  rs_push       in   1       write issued instruction into entry rs_push_pos
//  rs_push_pos   in   RS_W    target entry; always a value previously shown on rs_avail_pos
//  issue_op      in   OP_W    opcode
//  issue_imm     in   DATA_W  immediate
//  issue_pc      in   DATA_W  instruction pc
//  issue_robpos  in   ROB_W   destination ROB index
//  issue_vj      in   DATA_W  rs1 value, or ROB tag in low ROB_W bits when issue_qj=1
//  issue_qj      in   1       rs1 pending
//  issue_vk      in   DATA_W  rs2 value, or ROB tag when issue_qk=1
//  issue_qk      in   1       rs2 pending
//  alu_cdb_valid in   1       ALU result broadcast
//  alu_cdb_rob   in   ROB_W   ROB tag of the ALU result
//  alu_cdb_val   in   DATA_W  ALU result value
//  lsb_cdb_valid in   1       load result broadcast
//  lsb_cdb_rob   in   ROB_W   ROB tag of the load result
//  lsb_cdb_val   in   DATA_W  load result value
//  alu_valid     out  1       dispatch strobe, one cycle per instruction
//  alu_op        out  OP_W    dispatched opcode
//  alu_vj        out  DATA_W  dispatched rs1 value
//  alu_vk        out  DATA_W  dispatched rs2 value
//  alu_imm       out  DATA_W  dispatched immediate
//  alu_pc        out  DATA_W  dispatched pc
//  alu_robpos    out  ROB_W   dispatched ROB index
// BEHAVIOUR
//  - Entry fields: busy, op, imm, pc, robpos, vj, qj, vk, qk.
//  - Ready entry: busy && !qj && !qk, evaluated on registered state.
//  - Reset (rst_in=1 at posedge): all busy=0. alu_valid=0 and all alu_* outputs=0. Reset wins over everything.
//  - rdy_in=0: entries frozen, no push or dispatch, alu_valid<=0 at the next edge.
//  - flush=1 (rdy_in=1): all busy<=0, alu_valid<=0. A push in the same cycle is dropped.
//  - Dispatch at each edge:
//      - Select the lowest-index ready entry, copy it to the alu_* registers, set alu_valid<=1, clear its busy.
//      - If no entry is ready, alu_valid<=0.
//      - alu_* outputs hold their last value when alu_valid=0.
//  - Push: the entry at rs_push_pos is written with busy=1 and the issue fields.
//      - Earliest dispatch is the next edge, so alu_valid rises 2 cycles after rs_push.
//  - CDB update, every busy entry and both buses each cycle:
//      - If qj && vj[ROB_W-1:0]==cdb_rob, then vj<=cdb_val and qj<=0. Same rule for qk/vk.
//      - A same-cycle push is also compared: if the pushed tag matches a valid CDB tag, the value is captured at write time (bypass).
//      - If both buses carry the same tag, the ALU bus takes priority.
//  - A CDB wakeup makes an entry dispatchable at the following edge, not the same edge.
//  - Full: rs_avail=0. A push while full is illegal; the RS ignores it and the bench flags it.
//  - An entry freed by dispatch is visible on rs_avail/rs_avail_pos in the next cycle, not the current one.
//  - Push to the entry being dispatched in the same cycle cannot occur, since rs_avail_pos only shows non-busy entries.
// TESTING
//  - Reset: rst_in=1 for 2 cycles -> alu_valid=0, rs_avail=1, rs_avail_pos=0.
//  - Ready push: push op=ADD, vj=5, vk=7, qj=qk=0, robpos=3 -> 2 cycles later alu_valid=1, alu_vj=5, alu_vk=7, alu_robpos=3; entry 0 free again.
//  - Wakeup: push qj=1 with tag 2 -> no dispatch; alu_cdb_valid with rob=2, val=0x10 -> next edge vj=0x10, following edge alu_valid=1, alu_vj=0x10.
//  - Bypass and priority: push qk=1 with tag 4 while lsb_cdb rob=4, val=9 -> entry captured with vk=9, dispatch 2 cycles later. Both buses rob=4 -> ALU value taken.
//  - Fill and order: 16 pushes with qj=1 -> rs_avail=0. Wake entries 5 and 2 in the same cycle -> entry 2 dispatches first, then 5; rs_avail_pos=2 afterwards.
//  - Freeze and flush: rdy_in=0 with a ready entry -> no dispatch until rdy_in=1. flush with 3 busy entries plus a push -> all free, alu_valid=0.

Source files
------------

// File: rtl/reservation_station.sv
// ALU reservation station: buffers issued instructions, snoops the ALU/LSB result buses
// for pending source tags, and dispatches the lowest-index ready entry once per cycle.
module reservation_station #(
    parameter int RS_W   = 4,
    parameter int ROB_W  = 4,
    parameter int OP_W   = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush,
    output logic              rs_avail,
    output logic [RS_W-1:0]   rs_avail_pos,
    input  logic              rs_push,
    input  logic [RS_W-1:0]   rs_push_pos,
    input  logic [OP_W-1:0]   issue_op,
    input  logic [DATA_W-1:0] issue_imm,
    input  logic [DATA_W-1:0] issue_pc,
    input  logic [ROB_W-1:0]  issue_robpos,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic              issue_qj,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic              issue_qk,
    input  logic              alu_cdb_valid,
    input  logic [ROB_W-1:0]  alu_cdb_rob,
    input  logic [DATA_W-1:0] alu_cdb_val,
    input  logic              lsb_cdb_valid,
    input  logic [ROB_W-1:0]  lsb_cdb_rob,
    input  logic [DATA_W-1:0] lsb_cdb_val,
    output logic              alu_valid,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_vj,
    output logic [DATA_W-1:0] alu_vk,
    output logic [DATA_W-1:0] alu_imm,
    output logic [DATA_W-1:0] alu_pc,
    output logic [ROB_W-1:0]  alu_robpos
);

    localparam int RS_SIZE = 2 ** RS_W;

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] qj;
    logic [RS_SIZE-1:0] qk;
    logic [OP_W-1:0]    op     [RS_SIZE];
    logic [DATA_W-1:0]  imm    [RS_SIZE];
    logic [DATA_W-1:0]  pc     [RS_SIZE];
    logic [ROB_W-1:0]   robpos [RS_SIZE];
    logic [DATA_W-1:0]  vj     [RS_SIZE];
    logic [DATA_W-1:0]  vk     [RS_SIZE];

    logic [RS_SIZE-1:0] ready;
    logic               disp_any;
    logic [RS_W-1:0]    disp_pos;
    logic               push_ok;

    // {pending, value} after snooping both buses; per entry and for the incoming push
    logic [DATA_W:0]    j_nx [RS_SIZE];
    logic [DATA_W:0]    k_nx [RS_SIZE];
    logic [DATA_W:0]    push_j;
    logic [DATA_W:0]    push_k;

    // ALU bus is checked first so it wins when both buses carry the same tag
    function automatic logic [DATA_W:0] snoop(
        input logic              q,
        input logic [DATA_W-1:0] v,
        input logic              a_valid,
        input logic [ROB_W-1:0]  a_rob,
        input logic [DATA_W-1:0] a_val,
        input logic              l_valid,
        input logic [ROB_W-1:0]  l_rob,
        input logic [DATA_W-1:0] l_val
    );
        logic [DATA_W:0] res;
        res = {q, v};
        if (q && a_valid && v[ROB_W-1:0] == a_rob) begin
            res = {1'b0, a_val};
        end else if (q && l_valid && v[ROB_W-1:0] == l_rob) begin
            res = {1'b0, l_val};
        end
        return res;
    endfunction

    always_comb begin
        rs_avail     = ~&busy;
        rs_avail_pos = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) rs_avail_pos = RS_W'(i);
        end
    end

    always_comb begin
        ready    = busy & ~qj & ~qk;
        disp_any = |ready;
        disp_pos = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) disp_pos = RS_W'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            j_nx[i] = snoop(qj[i], vj[i], alu_cdb_valid, alu_cdb_rob, alu_cdb_val,
                            lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val);
            k_nx[i] = snoop(qk[i], vk[i], alu_cdb_valid, alu_cdb_rob, alu_cdb_val,
                            lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val);
        end
        push_j = snoop(issue_qj, issue_vj, alu_cdb_valid, alu_cdb_rob, alu_cdb_val,
                       lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val);
        push_k = snoop(issue_qk, issue_vk, alu_cdb_valid, alu_cdb_rob, alu_cdb_val,
                       lsb_cdb_valid, lsb_cdb_rob, lsb_cdb_val);
        // a push onto an occupied slot can only happen when full; it is dropped
        push_ok = rs_push && !busy[rs_push_pos];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy       <= '0;
            alu_valid  <= 1'b0;
            alu_op     <= '0;
            alu_vj     <= '0;
            alu_vk     <= '0;
            alu_imm    <= '0;
            alu_pc     <= '0;
            alu_robpos <= '0;
        end else if (!rdy_in) begin
            alu_valid <= 1'b0;
        end else if (flush) begin
            busy      <= '0;
            alu_valid <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i]) begin
                    qj[i] <= j_nx[i][DATA_W];
                    vj[i] <= j_nx[i][DATA_W-1:0];
                    qk[i] <= k_nx[i][DATA_W];
                    vk[i] <= k_nx[i][DATA_W-1:0];
                end
            end

            alu_valid <= disp_any;
            if (disp_any) begin
                alu_op         <= op[disp_pos];
                alu_vj         <= vj[disp_pos];
                alu_vk         <= vk[disp_pos];
                alu_imm        <= imm[disp_pos];
                alu_pc         <= pc[disp_pos];
                alu_robpos     <= robpos[disp_pos];
                busy[disp_pos] <= 1'b0;
            end

            if (push_ok) begin
                busy[rs_push_pos]   <= 1'b1;
                op[rs_push_pos]     <= issue_op;
                imm[rs_push_pos]    <= issue_imm;
                pc[rs_push_pos]     <= issue_pc;
                robpos[rs_push_pos] <= issue_robpos;
                qj[rs_push_pos]     <= push_j[DATA_W];
                vj[rs_push_pos]     <= push_j[DATA_W-1:0];
                qk[rs_push_pos]     <= push_k[DATA_W];
                vk[rs_push_pos]     <= push_k[DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: push/dispatch latency, CDB wakeup and bypass,
// bus priority, fill ordering, freeze and flush.
module tb_reservation_station;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic        rs_avail;
    logic [3:0]  rs_avail_pos;
    logic        rs_push;
    logic [3:0]  rs_push_pos;
    logic [5:0]  issue_op;
    logic [31:0] issue_imm;
    logic [31:0] issue_pc;
    logic [3:0]  issue_robpos;
    logic [31:0] issue_vj;
    logic        issue_qj;
    logic [31:0] issue_vk;
    logic        issue_qk;
    logic        alu_cdb_valid;
    logic [3:0]  alu_cdb_rob;
    logic [31:0] alu_cdb_val;
    logic        lsb_cdb_valid;
    logic [3:0]  lsb_cdb_rob;
    logic [31:0] lsb_cdb_val;
    logic        alu_valid;
    logic [5:0]  alu_op;
    logic [31:0] alu_vj;
    logic [31:0] alu_vk;
    logic [31:0] alu_imm;
    logic [31:0] alu_pc;
    logic [3:0]  alu_robpos;

    int n_checks = 0;
    int n_errors = 0;

    reservation_station dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush         (flush),
        .rs_avail      (rs_avail),
        .rs_avail_pos  (rs_avail_pos),
        .rs_push       (rs_push),
        .rs_push_pos   (rs_push_pos),
        .issue_op      (issue_op),
        .issue_imm     (issue_imm),
        .issue_pc      (issue_pc),
        .issue_robpos  (issue_robpos),
        .issue_vj      (issue_vj),
        .issue_qj      (issue_qj),
        .issue_vk      (issue_vk),
        .issue_qk      (issue_qk),
        .alu_cdb_valid (alu_cdb_valid),
        .alu_cdb_rob   (alu_cdb_rob),
        .alu_cdb_val   (alu_cdb_val),
        .lsb_cdb_valid (lsb_cdb_valid),
        .lsb_cdb_rob   (lsb_cdb_rob),
        .lsb_cdb_val   (lsb_cdb_val),
        .alu_valid     (alu_valid),
        .alu_op        (alu_op),
        .alu_vj        (alu_vj),
        .alu_vk        (alu_vk),
        .alu_imm       (alu_imm),
        .alu_pc        (alu_pc),
        .alu_robpos    (alu_robpos)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // one-cycle push; the slot must be shown free, an illegal push is flagged
    task automatic push(input logic [3:0] pos, input logic [5:0] op,
                        input logic [31:0] vj, input logic qj,
                        input logic [31:0] vk, input logic qk,
                        input logic [3:0] rob);
        chk("push_legal", {31'b0, rs_avail}, 32'd1);
        rs_push      = 1'b1;
        rs_push_pos  = pos;
        issue_op     = op;
        issue_imm    = 32'h1000 + 32'(rob);
        issue_pc     = 32'h400 + 32'(pos);
        issue_robpos = rob;
        issue_vj     = vj;
        issue_qj     = qj;
        issue_vk     = vk;
        issue_qk     = qk;
        step();
        rs_push = 1'b0;
    endtask

    task automatic cdb_idle();
        alu_cdb_valid = 1'b0;
        lsb_cdb_valid = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
        rs_push = 1'b0; rs_push_pos = '0;
        issue_op = '0; issue_imm = '0; issue_pc = '0; issue_robpos = '0;
        issue_vj = '0; issue_qj = 1'b0; issue_vk = '0; issue_qk = 1'b0;
        alu_cdb_valid = 1'b0; alu_cdb_rob = '0; alu_cdb_val = '0;
        lsb_cdb_valid = 1'b0; lsb_cdb_rob = '0; lsb_cdb_val = '0;

        // reset
        step(); step();
        chk("rst_valid", {31'b0, alu_valid}, 32'd0);
        chk("rst_avail", {31'b0, rs_avail}, 32'd1);
        chk("rst_pos", {28'b0, rs_avail_pos}, 32'd0);
        chk("rst_vj", alu_vj, 32'd0);
        chk("rst_robpos", {28'b0, alu_robpos}, 32'd0);
        rst_in = 1'b0;

        // ready push: dispatch two edges after rs_push
        push(4'd0, 6'd1, 32'd5, 1'b0, 32'd7, 1'b0, 4'd3);
        chk("rdy_no_disp_yet", {31'b0, alu_valid}, 32'd0);
        chk("rdy_pos_busy", {28'b0, rs_avail_pos}, 32'd1);
        step();
        chk("rdy_valid", {31'b0, alu_valid}, 32'd1);
        chk("rdy_vj", alu_vj, 32'd5);
        chk("rdy_vk", alu_vk, 32'd7);
        chk("rdy_robpos", {28'b0, alu_robpos}, 32'd3);
        chk("rdy_op", {26'b0, alu_op}, 32'd1);
        chk("rdy_pc", alu_pc, 32'h400);
        chk("rdy_imm", alu_imm, 32'h1003);
        chk("rdy_freed", {28'b0, rs_avail_pos}, 32'd0);
        step();
        chk("rdy_valid_drop", {31'b0, alu_valid}, 32'd0);
        chk("rdy_hold_vj", alu_vj, 32'd5);

        // wakeup: wrong tag leaves it pending, matching tag wakes it
        push(4'd0, 6'd2, 32'd2, 1'b1, 32'd1, 1'b0, 4'd5);
        alu_cdb_valid = 1'b1; alu_cdb_rob = 4'd3; alu_cdb_val = 32'hDEAD;
        step(); cdb_idle();
        chk("wk_wrong_tag", {31'b0, alu_valid}, 32'd0);
        step();
        chk("wk_wrong_tag2", {31'b0, alu_valid}, 32'd0);
        alu_cdb_valid = 1'b1; alu_cdb_rob = 4'd2; alu_cdb_val = 32'h10;
        step(); cdb_idle();
        chk("wk_not_same_edge", {31'b0, alu_valid}, 32'd0);
        step();
        chk("wk_valid", {31'b0, alu_valid}, 32'd1);
        chk("wk_vj", alu_vj, 32'h10);
        chk("wk_vk", alu_vk, 32'd1);
        chk("wk_robpos", {28'b0, alu_robpos}, 32'd5);
        step();

        // bypass from the LSB bus at push time
        lsb_cdb_valid = 1'b1; lsb_cdb_rob = 4'd4; lsb_cdb_val = 32'd9;
        push(4'd0, 6'd3, 32'd3, 1'b0, 32'd4, 1'b1, 4'd6);
        cdb_idle();
        chk("byp_no_disp_yet", {31'b0, alu_valid}, 32'd0);
        step();
        chk("byp_valid", {31'b0, alu_valid}, 32'd1);
        chk("byp_vk", alu_vk, 32'd9);
        chk("byp_vj", alu_vj, 32'd3);
        step();

        // both buses carry the same tag: ALU value wins
        alu_cdb_valid = 1'b1; alu_cdb_rob = 4'd4; alu_cdb_val = 32'h55;
        lsb_cdb_valid = 1'b1; lsb_cdb_rob = 4'd4; lsb_cdb_val = 32'h66;
        push(4'd0, 6'd4, 32'd8, 1'b0, 32'd4, 1'b1, 4'd7);
        cdb_idle();
        step();
        chk("prio_push_valid", {31'b0, alu_valid}, 32'd1);
        chk("prio_push_vk", alu_vk, 32'h55);
        step();
        push(4'd0, 6'd4, 32'd4, 1'b1, 32'd8, 1'b0, 4'd8);
        alu_cdb_valid = 1'b1; alu_cdb_rob = 4'd4; alu_cdb_val = 32'h77;
        lsb_cdb_valid = 1'b1; lsb_cdb_rob = 4'd4; lsb_cdb_val = 32'h88;
        step(); cdb_idle();
        step();
        chk("prio_res_valid", {31'b0, alu_valid}, 32'd1);
        chk("prio_res_vj", alu_vj, 32'h77);
        step();

        // fill all 16 entries, each waiting on tag == its index
        for (int i = 0; i < 16; i++) begin
            chk("fill_pos", {28'b0, rs_avail_pos}, i);
            push(4'(i), 6'd5, 32'(i), 1'b1, 32'h100 + 32'(i), 1'b0, 4'(i));
        end
        chk("full_avail", {31'b0, rs_avail}, 32'd0);
        chk("full_pos", {28'b0, rs_avail_pos}, 32'd0);
        chk("full_no_disp", {31'b0, alu_valid}, 32'd0);
        alu_cdb_valid = 1'b1; alu_cdb_rob = 4'd5; alu_cdb_val = 32'h50;
        lsb_cdb_valid = 1'b1; lsb_cdb_rob = 4'd2; lsb_cdb_val = 32'h20;
        step(); cdb_idle();
        chk("ord_not_yet", {31'b0, alu_valid}, 32'd0);
        step();
        chk("ord_first_valid", {31'b0, alu_valid}, 32'd1);
        chk("ord_first_rob", {28'b0, alu_robpos}, 32'd2);
        chk("ord_first_vj", alu_vj, 32'h20);
        chk("ord_first_vk", alu_vk, 32'h102);
        chk("ord_avail", {31'b0, rs_avail}, 32'd1);
        chk("ord_avail_pos", {28'b0, rs_avail_pos}, 32'd2);
        step();
        chk("ord_second_valid", {31'b0, alu_valid}, 32'd1);
        chk("ord_second_rob", {28'b0, alu_robpos}, 32'd5);
        chk("ord_second_vj", alu_vj, 32'h50);
        chk("ord_pos_after", {28'b0, rs_avail_pos}, 32'd2);
        step();
        chk("ord_idle", {31'b0, alu_valid}, 32'd0);

        // flush empties the full station
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl1_pos", {28'b0, rs_avail_pos}, 32'd0);
        chk("fl1_valid", {31'b0, alu_valid}, 32'd0);

        // freeze holds a ready entry
        push(4'd0, 6'd6, 32'hA, 1'b0, 32'hB, 1'b0, 4'd9);
        rdy_in = 1'b0;
        step();
        chk("frz_valid1", {31'b0, alu_valid}, 32'd0);
        step();
        chk("frz_valid2", {31'b0, alu_valid}, 32'd0);
        chk("frz_pos", {28'b0, rs_avail_pos}, 32'd1);
        rdy_in = 1'b1;
        step();
        chk("frz_release_valid", {31'b0, alu_valid}, 32'd1);
        chk("frz_release_vj", alu_vj, 32'hA);
        chk("frz_release_rob", {28'b0, alu_robpos}, 32'd9);
        step();

        // flush with three pending entries plus a same-cycle push
        push(4'd0, 6'd7, 32'd10, 1'b1, 32'd0, 1'b0, 4'd1);
        push(4'd1, 6'd7, 32'd11, 1'b1, 32'd0, 1'b0, 4'd2);
        push(4'd2, 6'd7, 32'd12, 1'b1, 32'd0, 1'b0, 4'd3);
        chk("fl2_pos_before", {28'b0, rs_avail_pos}, 32'd3);
        flush = 1'b1;
        push(4'd3, 6'd8, 32'd1, 1'b0, 32'd2, 1'b0, 4'd4);
        flush = 1'b0;
        chk("fl2_avail", {31'b0, rs_avail}, 32'd1);
        chk("fl2_pos", {28'b0, rs_avail_pos}, 32'd0);
        chk("fl2_valid", {31'b0, alu_valid}, 32'd0);
        step();
        chk("fl2_push_dropped", {31'b0, alu_valid}, 32'd0);
        alu_cdb_valid = 1'b1; alu_cdb_rob = 4'd10; alu_cdb_val = 32'h99;
        step(); cdb_idle();
        step();
        chk("fl2_no_ghost", {31'b0, alu_valid}, 32'd0);

        // reset wins over a push
        rst_in = 1'b1;
        push(4'd0, 6'd9, 32'd1, 1'b0, 32'd1, 1'b0, 4'd1);
        rst_in = 1'b0;
        chk("rstw_pos", {28'b0, rs_avail_pos}, 32'd0);
        chk("rstw_vj", alu_vj, 32'd0);
        step();
        chk("rstw_valid", {31'b0, alu_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
